// File: rtl/spi_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single spi engine.
//
// Handshake: req_n is a level request that the requester holds high, with
// data_tx_n/width_16_n stable, until the arbiter answers with a one-cycle
// done_n pulse; err_n and rx_n are valid in that same cycle. The requester
// drops req_n in the cycle after done_n. If req_n is still high once the
// arbiter is back in IDLE, that is a new request. Towards the engine,
// spi_start is held until spi_busy is seen high, and the transfer is
// complete when spi_busy falls again.
//
// Modports: slave = arbiter side, master = requester/engine side.
interface spi_arbiter_if;
  logic        req_0;
  logic        req_1;
  logic        width_16_0;
  logic        width_16_1;
  logic [15:0] data_tx_0;
  logic [15:0] data_tx_1;
  logic        done_0;
  logic        done_1;
  logic        err_0;
  logic        err_1;
  logic [7:0]  rx_0;
  logic [7:0]  rx_1;
  logic [1:0]  cs_n;
  logic        spi_start;
  logic        spi_width_16;
  logic [15:0] spi_data_tx;
  logic [7:0]  spi_data_rx;
  logic        spi_busy;

  modport slave (
    input  req_0, req_1, width_16_0, width_16_1, data_tx_0, data_tx_1,
    input  spi_data_rx, spi_busy,
    output done_0, done_1, err_0, err_1, rx_0, rx_1, cs_n,
    output spi_start, spi_width_16, spi_data_tx
  );

  modport master (
    output req_0, req_1, width_16_0, width_16_1, data_tx_0, data_tx_1,
    output spi_data_rx, spi_busy,
    input  done_0, done_1, err_0, err_1, rx_0, rx_1, cs_n,
    input  spi_start, spi_width_16, spi_data_tx
  );
endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one spi engine between two requesters with round-robin
// grant and sequences a complete transfer (cs setup, start/busy handshake,
// wait for completion, cs hold, rx capture, done pulse).
//
// Ports:
//   raw_clk  clock, all state on posedge
//   reset    asynchronous, active-high
//   bus      spi_arbiter_if.slave (requester side + spi engine side)
//   o_state  current FSM state (IDLE=0 SETUP=1 START=2 XFER=3 HOLD=4 DONE=5)
module spi_arbiter #(
  parameter int unsigned CS_SETUP      = 4,
  parameter int unsigned CS_HOLD       = 4,
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic         raw_clk,
  input  logic         reset,
  spi_arbiter_if.slave bus,
  output logic [2:0]   o_state
);

  // Terminal count of each timed state; a zero parameter behaves as 1 cycle.
  localparam logic [7:0] SETUP_LAST = (CS_SETUP == 0) ? 8'd0 : 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LAST  = (CS_HOLD == 0) ? 8'd0 : 8'(CS_HOLD - 1);
  localparam logic [7:0] TMO_LAST   = (START_TIMEOUT == 0) ? 8'd0 : 8'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SETUP, START, XFER, HOLD, DONE} state_t;

  state_t      r_state, w_state;
  logic        r_grant, w_grant;
  logic        r_last_grant, w_last_grant;
  logic [7:0]  r_cnt, w_cnt;
  logic        r_flag, w_flag;
  logic [1:0]  r_cs_n, w_cs_n;
  logic        r_start, w_start;
  logic        r_width, w_width;
  logic [15:0] r_tx, w_tx;
  logic [1:0]  r_done, w_done;
  logic [1:0]  r_err, w_err;
  logic [7:0]  r_rx0, w_rx0;
  logic [7:0]  r_rx1, w_rx1;
  logic        w_pick;

  always_comb begin
    w_state      = r_state;
    w_grant      = r_grant;
    w_last_grant = r_last_grant;
    w_cnt        = r_cnt;
    w_flag       = r_flag;
    w_cs_n       = r_cs_n;
    w_start      = r_start;
    w_width      = r_width;
    w_tx         = r_tx;
    w_done       = 2'b00;
    w_err        = 2'b00;
    w_rx0        = r_rx0;
    w_rx1        = r_rx1;
    w_pick       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_0 || bus.req_1) begin
          // On a tie the requester that was not served last wins.
          w_pick       = (bus.req_0 && bus.req_1) ? ~r_last_grant : bus.req_1;
          w_grant      = w_pick;
          w_last_grant = w_pick;
          w_tx         = w_pick ? bus.data_tx_1 : bus.data_tx_0;
          w_width      = w_pick ? bus.width_16_1 : bus.width_16_0;
          w_cs_n       = w_pick ? 2'b01 : 2'b10;
          w_cnt        = 8'd0;
          w_state      = SETUP;
        end
      end
      SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_start = 1'b1;
          w_cnt   = 8'd0;
          w_state = START;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      START: begin
        // A busy arriving in the last allowed cycle still counts as started.
        if (bus.spi_busy) begin
          w_start = 1'b0;
          w_state = XFER;
        end else if (r_cnt == TMO_LAST) begin
          w_start = 1'b0;
          w_flag  = 1'b1;
          w_cnt   = 8'd0;
          w_state = HOLD;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      XFER: begin
        if (!bus.spi_busy) begin
          w_cnt   = 8'd0;
          w_state = HOLD;
        end
      end
      HOLD: begin
        // done/err/rx are registered on the way into DONE so they appear
        // together with cs_n released, during the single DONE cycle.
        if (r_cnt == HOLD_LAST) begin
          w_cs_n  = 2'b11;
          w_flag  = 1'b0;
          w_state = DONE;
          if (r_grant) begin
            w_done[1] = 1'b1;
            w_err[1]  = r_flag;
            if (!r_flag) w_rx1 = bus.spi_data_rx;
          end else begin
            w_done[0] = 1'b1;
            w_err[0]  = r_flag;
            if (!r_flag) w_rx0 = bus.spi_data_rx;
          end
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      DONE:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= 8'd0;
      r_flag       <= 1'b0;
      r_cs_n       <= 2'b11;
      r_start      <= 1'b0;
      r_width      <= 1'b0;
      r_tx         <= 16'd0;
      r_done       <= 2'b00;
      r_err        <= 2'b00;
      r_rx0        <= 8'd0;
      r_rx1        <= 8'd0;
    end else begin
      r_state      <= w_state;
      r_grant      <= w_grant;
      r_last_grant <= w_last_grant;
      r_cnt        <= w_cnt;
      r_flag       <= w_flag;
      r_cs_n       <= w_cs_n;
      r_start      <= w_start;
      r_width      <= w_width;
      r_tx         <= w_tx;
      r_done       <= w_done;
      r_err        <= w_err;
      r_rx0        <= w_rx0;
      r_rx1        <= w_rx1;
    end
  end

  assign bus.cs_n         = r_cs_n;
  assign bus.spi_start    = r_start;
  assign bus.spi_width_16 = r_width;
  assign bus.spi_data_tx  = r_tx;
  assign bus.done_0       = r_done[0];
  assign bus.done_1       = r_done[1];
  assign bus.err_0        = r_err[0];
  assign bus.err_1        = r_err[1];
  assign bus.rx_0         = r_rx0;
  assign bus.rx_1         = r_rx1;
  assign o_state          = r_state;

endmodule

// File: tb/tb_spi_arbiter.sv
// Testbench for spi_arbiter: randomized rounds of requests against a
// transaction-level model (service order, expected rx/err per requester),
// a behavioural spi engine, a done monitor with an expected queue, plus
// directed latency, timeout, reset and zero-parameter checks.
module tb_spi_arbiter;
  localparam int CS_HOLD       = 4;
  localparam int START_TIMEOUT = 16;

  logic raw_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 raw_clk = ~raw_clk;

  spi_arbiter_if bus ();
  spi_arbiter_if bus_z ();
  logic [2:0] dbg_state;
  logic [2:0] dbg_state_z;

  spi_arbiter #(.CS_SETUP(4), .CS_HOLD(4), .START_TIMEOUT(16)) u_dut (
    .raw_clk(raw_clk), .reset(reset), .bus(bus), .o_state(dbg_state)
  );
  spi_arbiter #(.CS_SETUP(0), .CS_HOLD(0), .START_TIMEOUT(16)) u_dut_z (
    .raw_clk(raw_clk), .reset(reset), .bus(bus_z), .o_state(dbg_state_z)
  );

  int n_checks = 0;
  int n_errors = 0;
  int both_low = 0;

  // expected completion: {who, err, rx[7:0], width, tx[15:0]}
  logic [26:0] exp_q[$];
  // spi engine plan, in service order: {who, no_busy, busy_len[7:0], rx[7:0]}
  logic [17:0] plan_q[$];
  logic        m_last;
  logic [7:0]  m_rx [2];
  logic [15:0] seen_tx;
  logic        seen_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
  endtask

  // Model: transfers are served in the order planned; err keeps the old rx.
  task automatic plan_xfer(input logic who, input logic nb, input logic [7:0] bl,
                           input logic [7:0] rv, input logic [15:0] tx, input logic w,
                           input logic push_exp);
    logic [7:0] er;
    plan_q.push_back({who, nb, bl, rv});
    m_last = who;
    if (push_exp) begin
      er = nb ? m_rx[who] : rv;
      m_rx[who] = er;
      exp_q.push_back({who, nb, er, w, tx});
    end
  endtask

  task automatic raise(input logic who, input logic [15:0] tx, input logic w);
    if (who) begin
      bus.data_tx_1 = tx; bus.width_16_1 = w; bus.req_1 = 1'b1;
    end else begin
      bus.data_tx_0 = tx; bus.width_16_0 = w; bus.req_0 = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((exp_q.size() != 0 || plan_q.size() != 0 || bus.req_0 || bus.req_1 ||
            bus.spi_busy) && c < 2000) begin
      @(negedge raw_clk);
      c++;
    end
    if (c >= 2000) fail_now("idle_timeout");
    @(negedge raw_clk);
  endtask

  task automatic do_round(input int kind);
    logic [15:0] tx [2];
    logic        w  [2];
    logic        nb [2];
    logic [7:0]  bl [2];
    logic [7:0]  rv [2];
    logic        first;
    int          c;
    for (int i = 0; i < 2; i++) begin
      tx[i] = 16'($urandom);
      w[i]  = 1'($urandom_range(0, 1));
      nb[i] = ($urandom_range(0, 5) == 0);
      bl[i] = 8'($urandom_range(1, 10));
      rv[i] = 8'($urandom);
    end
    case (kind)
      0, 1: begin
        first = (kind == 1);
        plan_xfer(first, nb[first], bl[first], rv[first], tx[first], w[first], 1'b1);
        @(negedge raw_clk);
        raise(first, tx[first], w[first]);
      end
      2: begin
        first = ~m_last;
        plan_xfer(first, nb[first], bl[first], rv[first], tx[first], w[first], 1'b1);
        plan_xfer(~first, nb[~first], bl[~first], rv[~first], tx[~first], w[~first], 1'b1);
        @(negedge raw_clk);
        raise(1'b0, tx[0], w[0]);
        raise(1'b1, tx[1], w[1]);
      end
      default: begin
        // req_1 arrives while requester 0 already owns the bus
        plan_xfer(1'b0, nb[0], bl[0], rv[0], tx[0], w[0], 1'b1);
        plan_xfer(1'b1, nb[1], bl[1], rv[1], tx[1], w[1], 1'b1);
        @(negedge raw_clk);
        raise(1'b0, tx[0], w[0]);
        c = 0;
        while (bus.cs_n == 2'b11 && c < 20) begin
          @(negedge raw_clk);
          c++;
        end
        if (c >= 20) fail_now("late_req_cs_wait");
        repeat (2) @(negedge raw_clk);
        raise(1'b1, tx[1], w[1]);
      end
    endcase
    wait_idle();
  endtask

  // Requesters drop their request in the cycle after done.
  initial begin
    forever begin
      @(negedge raw_clk);
      if (bus.done_0) bus.req_0 = 1'b0;
      if (bus.done_1) bus.req_1 = 1'b0;
    end
  end

  // Behavioural spi engine: busy one cycle after start, for busy_len cycles.
  initial begin
    logic [17:0] p;
    int          c;
    bus.spi_busy    = 1'b0;
    bus.spi_data_rx = 8'd0;
    forever begin
      @(negedge raw_clk);
      if (bus.spi_start && !reset) begin
        if (plan_q.size() == 0) begin
          fail_now("unplanned_start");
          @(negedge raw_clk);
        end else begin
          p       = plan_q.pop_front();
          seen_tx = bus.spi_data_tx;
          seen_w  = bus.spi_width_16;
          chk("cs_grant", 32'(bus.cs_n), p[17] ? 32'h1 : 32'h2);
          if (p[16]) begin
            c = 0;
            while (bus.spi_start && c < 200) begin
              c++;
              @(negedge raw_clk);
            end
            chk("start_timeout_len", 32'(c), 32'(START_TIMEOUT));
          end else begin
            @(negedge raw_clk);
            bus.spi_busy = 1'b1;
            repeat (int'(p[15:8])) @(negedge raw_clk);
            bus.spi_busy    = 1'b0;
            bus.spi_data_rx = p[7:0];
          end
        end
      end
    end
  end

  // Monitor: pops an expectation whenever a done pulse appears.
  initial begin
    logic [26:0] e;
    logic        prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge raw_clk);
      if (bus.cs_n == 2'b00) both_low++;
      if (bus.done_0 || bus.done_1) begin
        chk("done_single_cycle", 32'(prev_done), 32'h0);
        if (exp_q.size() == 0) begin
          chk("done_expected", 32'({bus.done_1, bus.done_0}), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("done_who", 32'({bus.done_1, bus.done_0}), e[26] ? 32'h2 : 32'h1);
          chk("err", 32'(e[26] ? bus.err_1 : bus.err_0), 32'(e[25]));
          chk("err_other", 32'(e[26] ? bus.err_0 : bus.err_1), 32'h0);
          chk("rx", 32'(e[26] ? bus.rx_1 : bus.rx_0), 32'(e[24:17]));
          chk("spi_width", 32'(seen_w), 32'(e[16]));
          chk("spi_tx", 32'(seen_tx), 32'(e[15:0]));
          chk("cs_released", 32'(bus.cs_n), 32'h3);
        end
      end
      prev_done = bus.done_0 | bus.done_1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    m_last = 1'b1;
    m_rx[0] = 8'd0; m_rx[1] = 8'd0;
    bus.req_0 = 1'b0; bus.req_1 = 1'b0;
    bus.width_16_0 = 1'b0; bus.width_16_1 = 1'b0;
    bus.data_tx_0 = 16'd0; bus.data_tx_1 = 16'd0;
    bus_z.req_0 = 1'b0; bus_z.req_1 = 1'b0;
    bus_z.width_16_0 = 1'b0; bus_z.width_16_1 = 1'b0;
    bus_z.data_tx_0 = 16'd0; bus_z.data_tx_1 = 16'd0;
    bus_z.spi_busy = 1'b0; bus_z.spi_data_rx = 8'd0;
    repeat (3) @(negedge raw_clk);
    reset = 1'b0;
    @(negedge raw_clk);

    // reset state
    chk("rst_cs_n", 32'(bus.cs_n), 32'h3);
    chk("rst_start", 32'(bus.spi_start), 32'h0);
    chk("rst_width", 32'(bus.spi_width_16), 32'h0);
    chk("rst_tx", 32'(bus.spi_data_tx), 32'h0);
    chk("rst_done", 32'({bus.done_1, bus.done_0, bus.err_1, bus.err_0}), 32'h0);
    chk("rst_rx", 32'({bus.rx_1, bus.rx_0}), 32'h0);

    // single req_0 with latency checks
    plan_xfer(1'b0, 1'b0, 8'd8, 8'h3C, 16'h00A5, 1'b0, 1'b1);
    @(negedge raw_clk);
    raise(1'b0, 16'h00A5, 1'b0);
    @(negedge raw_clk);
    chk("lat_cs_low", 32'(bus.cs_n), 32'h2);
    repeat (3) @(negedge raw_clk);
    chk("lat_start_pre", 32'(bus.spi_start), 32'h0);
    @(negedge raw_clk);
    chk("lat_start", 32'(bus.spi_start), 32'h1);
    c = 0;
    while (!bus.done_0 && c < 100) begin
      @(negedge raw_clk);
      c++;
    end
    chk("lat_done", 32'(c), 32'(1 + 8 + CS_HOLD + 1));
    wait_idle();
    chk("idle_cs_n", 32'(bus.cs_n), 32'h3);

    // start timeout, then a normal transfer
    plan_xfer(1'b0, 1'b1, 8'd1, 8'h77, 16'h1234, 1'b1, 1'b1);
    @(negedge raw_clk);
    raise(1'b0, 16'h1234, 1'b1);
    wait_idle();
    do_round(0);

    // ties alternate
    repeat (4) do_round(2);
    do_round(3);

    for (int i = 0; i < 30; i++) do_round($urandom_range(0, 3));

    // reset during XFER
    plan_xfer(1'b0, 1'b0, 8'd20, 8'h99, 16'hCAFE, 1'b0, 1'b0);
    @(negedge raw_clk);
    raise(1'b0, 16'hCAFE, 1'b0);
    c = 0;
    while (!bus.spi_busy && c < 50) begin
      @(negedge raw_clk);
      c++;
    end
    if (c >= 50) fail_now("busy_wait");
    repeat (3) @(negedge raw_clk);
    #2;
    reset = 1'b1;
    bus.req_0 = 1'b0;
    #1;
    chk("arst_cs_n", 32'(bus.cs_n), 32'h3);
    chk("arst_start", 32'(bus.spi_start), 32'h0);
    chk("arst_done", 32'({bus.done_1, bus.done_0}), 32'h0);
    c = 0;
    while (bus.spi_busy && c < 100) begin
      @(negedge raw_clk);
      c++;
    end
    if (c >= 100) fail_now("busy_drain");
    @(negedge raw_clk);
    reset = 1'b0;
    m_last = 1'b1;
    m_rx[0] = 8'd0; m_rx[1] = 8'd0;
    @(negedge raw_clk);
    chk("arst_rx", 32'({bus.rx_1, bus.rx_0}), 32'h0);
    do_round(2);

    // zero CS_SETUP/CS_HOLD build, 16-bit width
    @(negedge raw_clk);
    bus_z.data_tx_0 = 16'hBEEF; bus_z.width_16_0 = 1'b1; bus_z.req_0 = 1'b1;
    @(negedge raw_clk);
    chk("z_cs_low", 32'(bus_z.cs_n), 32'h2);
    chk("z_start_pre", 32'(bus_z.spi_start), 32'h0);
    @(negedge raw_clk);
    chk("z_start", 32'(bus_z.spi_start), 32'h1);
    chk("z_width", 32'(bus_z.spi_width_16), 32'h1);
    chk("z_tx", 32'(bus_z.spi_data_tx), 32'hBEEF);
    bus_z.spi_busy = 1'b1;
    repeat (3) @(negedge raw_clk);
    bus_z.spi_busy = 1'b0;
    bus_z.spi_data_rx = 8'h5A;
    @(negedge raw_clk);
    chk("z_hold", 32'({bus_z.done_0, bus_z.cs_n}), 32'h2);
    @(negedge raw_clk);
    chk("z_done", 32'({bus_z.done_1, bus_z.done_0, bus_z.err_0}), 32'h2);
    chk("z_rx", 32'(bus_z.rx_0), 32'h5A);
    chk("z_cs_release", 32'(bus_z.cs_n), 32'h3);
    bus_z.req_0 = 1'b0;
    repeat (2) @(negedge raw_clk);
    chk("z_done_pulse", 32'(bus_z.done_0), 32'h0);

    chk("cs_never_both_low", 32'(both_low), 32'h0);
    chk("final_idle", 32'({dbg_state, dbg_state_z}), 32'h0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
